regfile_nw_decoded: RTL and testbench

- Parametrised general-register file for the PA-RISC datapath; successor to the fixed 5-to-32 enable-gated decoder.
- The write-address decoder is generalised to NREG outputs and drives a bank of NREG x WIDTH registers.
- Provides two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero, matching PA-RISC GR0 semantics.

---
 rtl/regfile_nw_decoded.sv | 97 +++++++++
 tb/tb_regfile_nw_decoded.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_nw_decoded.sv
// regfile_nw_decoded: parametrised general-register file for the PA-RISC datapath.
// Register 0 is hardwired to zero.
//
// Ports
//   CLK     rising-edge clock
//   RST     synchronous active-high reset (clears registers and WR_CNT)
//   WE      write enable (decoder enable)
//   WA/WD   write address / write data
//   RA_A/B  read addresses; RD_A/B combinational read data
//   WDEC    one-hot decoded write strobe for the current cycle (combinational)
//   WR_CNT  saturating count of committed writes since reset
//
// Optional build macro REGFILE_BYPASS_EN adds same-cycle write-to-read
// forwarding on both read ports; without it a same-cycle read sees old data.

module regfile_nw_decoded_cell #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK) begin
    if (RST)     q <= '0;
    else if (en) q <= d;
  end
endmodule

module regfile_nw_decoded #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  WD,
  input  logic [ADDR_W-1:0] RA_A,
  input  logic [ADDR_W-1:0] RA_B,
  output logic [WIDTH-1:0]  RD_A,
  output logic [WIDTH-1:0]  RD_B,
  output logic [NREG-1:0]   WDEC,
  output logic [15:0]       WR_CNT
);

  // Storage for registers 1..NREG-1; register 0 has no storage at all.
  logic [NREG-1:1][WIDTH-1:0] mem;
  logic                       commit;

  // Compare-per-output decode: an out-of-range or unknown WA matches no
  // output, so the strobe stays all-zero and the write is dropped.
  always_comb begin
    WDEC = '0;
    for (int i = 0; i < NREG; i++)
      if (WE && (WA == ADDR_W'(i))) WDEC[i] = 1'b1;
  end

  // WDEC[0] may fire but never commits.
  assign commit = |WDEC[NREG-1:1];

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    regfile_nw_decoded_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK (CLK),
      .RST (RST),
      .en  (WDEC[g]),
      .d   (WD),
      .q   (mem[g])
    );
  end

  function automatic logic [WIDTH-1:0] rd_sel(input logic [ADDR_W-1:0] ra,
                                              input logic [NREG-1:1][WIDTH-1:0] m);
    rd_sel = '0;
    for (int i = 1; i < NREG; i++)
      if (ra == ADDR_W'(i)) rd_sel = m[i];
  endfunction

  always_comb begin
    RD_A = rd_sel(RA_A, mem);
    RD_B = rd_sel(RA_B, mem);
`ifdef REGFILE_BYPASS_EN
    // commit already excludes WA==0 and WA>=NREG, so forwarding never
    // leaks a discarded write onto a read port.
    if (commit && (WA == RA_A)) RD_A = WD;
    if (commit && (WA == RA_B)) RD_B = WD;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST)                              WR_CNT <= '0;
    else if (commit && WR_CNT != 16'hFFFF) WR_CNT <= WR_CNT + 16'd1;
  end

endmodule

// File: tb/tb_regfile_nw_decoded.sv
module tb_regfile_nw_decoded;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  wa, ra_a, ra_b;
  logic [31:0] wd;
  logic [31:0] rd_a, rd_b, rd_a16, rd_b16;
  logic [31:0] wdec;
  logic [15:0] wdec16;
  logic [15:0] cnt, cnt16;

  always #5 clk = ~clk;

  regfile_nw_decoded dut (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd), .RA_A(ra_a), .RA_B(ra_b),
    .RD_A(rd_a), .RD_B(rd_b), .WDEC(wdec), .WR_CNT(cnt)
  );

  regfile_nw_decoded #(.NREG(16)) dut16 (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd), .RA_A(ra_a), .RA_B(ra_b),
    .RD_A(rd_a16), .RD_B(rd_b16), .WDEC(wdec16), .WR_CNT(cnt16)
  );

  typedef enum logic [1:0] {F_RDA, F_RDB, F_WDEC, F_CNT} fld_e;
  typedef struct {
    string       name;
    bit          d16;
    fld_e        f;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void ex(string n, bit d16, fld_e f, logic [31:0] v);
    exp_t e;
    e.name = n; e.d16 = d16; e.f = f; e.v = v;
    sb.push_back(e);
  endfunction

  // Monitor: outputs are combinational, so every cycle's expectations are
  // compared at the falling edge, midway between input change and commit.
  exp_t        me;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      me = sb.pop_front();
      case (me.f)
        F_RDA:   act = me.d16 ? rd_a16 : rd_a;
        F_RDB:   act = me.d16 ? rd_b16 : rd_b;
        F_WDEC:  act = me.d16 ? {16'h0, wdec16} : wdec;
        default: act = me.d16 ? {16'h0, cnt16} : {16'h0, cnt};
      endcase
      n_chk++;
      if (act !== me.v) begin
        n_fail++;
        $display("FAIL %s (n%0d): got %h expected %h", me.name, me.d16 ? 16 : 32, act, me.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(bit w, int a, logic [31:0] d, int pa, int pb);
    we = w; wa = 5'(a); wd = d; ra_a = 5'(pa); ra_b = 5'(pb);
  endtask

  int          sw_wa  [6] = '{0, 1, 2, 15, 21, 31};
  logic [31:0] sw_e32 [6] = '{32'h1, 32'h2, 32'h4, 32'h8000, 32'h20_0000, 32'h8000_0000};
  logic [31:0] sw_e16 [6] = '{32'h1, 32'h2, 32'h4, 32'h8000, 32'h0, 32'h0};

  initial begin
    rst = 1'b1;
    set(0, 0, 0, 7, 0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    ex("rst_cnt", 0, F_CNT, 0);  ex("rst_cnt", 1, F_CNT, 0);
    ex("rst_rda", 0, F_RDA, 0);  ex("rst_wdec", 0, F_WDEC, 0);
    tick();

    // Decode sweep
    for (int i = 0; i < 6; i++) begin
      set(1, sw_wa[i], 0, 0, 0);
      ex("wdec_sweep", 0, F_WDEC, sw_e32[i]);
      ex("wdec_sweep", 1, F_WDEC, sw_e16[i]);
      tick();
    end
    set(0, 21, 0, 0, 0);
    ex("wdec_we0", 0, F_WDEC, 0);  ex("wdec_we0", 1, F_WDEC, 0);
    ex("sweep_cnt", 0, F_CNT, 5);  ex("sweep_cnt", 1, F_CNT, 3);
    tick();
    we = 1'b1; wa = 'x; wd = 0;
    if ($isunknown(wa)) ex("wdec_x", 0, F_WDEC, 0);
    else                ex("wdec_x", 0, F_WDEC, 32'd1 << wa);
    tick();

    // Reset clears registers, WE during reset does not commit
    set(1, 7, 32'hDEADBEEF, 7, 0);
`ifdef REGFILE_BYPASS_EN
    ex("wr7_same", 0, F_RDA, 32'hDEADBEEF);
`else
    ex("wr7_same", 0, F_RDA, 0);
`endif
    tick();
    set(0, 7, 0, 7, 0);
    ex("wr7_rd", 0, F_RDA, 32'hDEADBEEF);  ex("wr7_rd", 1, F_RDA, 32'hDEADBEEF);
    tick();
    rst = 1'b1;
    set(1, 7, 32'h1234_5678, 7, 0);
    tick();
    rst = 1'b0;
    set(0, 0, 0, 7, 0);
    ex("rst_clr", 0, F_RDA, 0);  ex("rst_clr", 1, F_RDA, 0);
    ex("rst_cnt2", 0, F_CNT, 0); ex("rst_cnt2", 1, F_CNT, 0);
    tick();

    // Write/read
    set(1, 3, 32'h0000_1234, 3, 31);
    tick();
    set(1, 31, 32'hFFFF_0000, 3, 31);
    ex("rd3", 0, F_RDA, 32'h1234);
    tick();
    set(0, 0, 0, 3, 31);
    ex("rd3", 0, F_RDA, 32'h1234);        ex("rd3", 1, F_RDA, 32'h1234);
    ex("rd31", 0, F_RDB, 32'hFFFF_0000);  ex("rd31_oor", 1, F_RDB, 0);
    ex("wr_cnt2", 0, F_CNT, 2);           ex("wr_cnt2", 1, F_CNT, 1);
    tick();

    // GR0
    set(1, 0, 32'hFFFF_FFFF, 0, 0);
    ex("gr0_wdec", 0, F_WDEC, 1);  ex("gr0_wdec", 1, F_WDEC, 1);
    ex("gr0_same", 0, F_RDA, 0);
    tick();
    set(0, 0, 0, 0, 0);
    ex("gr0_rd", 0, F_RDA, 0);  ex("gr0_cnt", 0, F_CNT, 2);
    tick();

    // Same-cycle hazard; port B reads a different register
    set(1, 10, 32'hA, 0, 0);
    tick();
    set(1, 10, 32'hB, 10, 3);
`ifdef REGFILE_BYPASS_EN
    ex("haz_pre", 0, F_RDA, 32'hB);  ex("haz_pre", 1, F_RDA, 32'hB);
`else
    ex("haz_pre", 0, F_RDA, 32'hA);  ex("haz_pre", 1, F_RDA, 32'hA);
`endif
    ex("haz_b", 0, F_RDB, 32'h1234);
    tick();
    set(0, 0, 0, 10, 10);
    ex("haz_post", 0, F_RDA, 32'hB);  ex("haz_post", 1, F_RDA, 32'hB);
    ex("same_reg_b", 0, F_RDB, 32'hB);
    ex("haz_cnt", 0, F_CNT, 4);       ex("haz_cnt", 1, F_CNT, 3);
    tick();

    // Out-of-range write on the 16-register build
    set(1, 20, 32'h55, 20, 0);
    ex("oor_wdec", 1, F_WDEC, 0);  ex("oor_wdec", 0, F_WDEC, 32'h10_0000);
    ex("oor_rd_same", 1, F_RDA, 0);
    tick();
    set(0, 0, 0, 20, 0);
    ex("oor_rd", 1, F_RDA, 0);  ex("oor_cnt", 1, F_CNT, 3);
    ex("r20_rd", 0, F_RDA, 32'h55);  ex("r20_cnt", 0, F_CNT, 5);
    tick();

    // Saturation: 65535 more commits push both counters to the ceiling
    for (int i = 0; i < 65535; i++) begin
      set(1, 1, 32'(i), 0, 0);
      tick();
    end
    set(0, 0, 0, 1, 0);
    ex("sat", 0, F_CNT, 32'hFFFF);  ex("sat", 1, F_CNT, 32'hFFFF);
    ex("sat_rd", 0, F_RDA, 32'd65534);
    tick();
    set(1, 2, 32'h77, 0, 0);
    tick();
    set(0, 0, 0, 2, 0);
    ex("sat_hold", 0, F_CNT, 32'hFFFF);  ex("sat_hold", 1, F_CNT, 32'hFFFF);
    ex("sat_wr", 0, F_RDA, 32'h77);
    tick();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
